// File: rtl/db_scan_ctrl.sv
// Purpose: multi-channel switch debouncer; one shared prescaler tick, then scan one channel per clock.
// Latency: 2 sync clocks + CONFIRM tick periods + (idx+1) clocks from a stable switch change to db.
// Backpressure: none; en low freezes the prescaler and aborts any in-progress scan.
module db_scan_ctrl #(
    parameter int NCH       = 4,
    parameter int TICK_BITS = 19,
    parameter int CONFIRM   = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [NCH-1:0] sw,
    output logic [NCH-1:0] db,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           tick,
    output logic           busy
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW:0]   CONF_V = (CW + 1)'(CONFIRM);
    localparam logic [IW-1:0] LAST   = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1
    } state_t;

    logic [NCH-1:0]       sync1;
    logic [NCH-1:0]       sw_s;
    logic [TICK_BITS-1:0] q;
    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 svc;
    logic [CW-1:0]        cnt [NCH];
    logic [CW-1:0]        cnt_cur;
    logic [CW:0]          cnt_inc;
    logic                 sw_cur;
    logic                 db_cur;

    // Two-flop synchronizer on the raw switches; runs every cycle independent of en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sw_s  <= '0;
        end else begin
            sync1 <= sw;
            sw_s  <= sync1;
        end
    end

    // Free-running prescaler while enabled; tick fires on the wrap from all-ones to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            tick <= 1'b0;
        end else if (en) begin
            q    <= q + 1'b1;
            tick <= &q;
        end else begin
            tick <= 1'b0;
        end
    end

    // Scan FSM state and channel index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: a tick launches one pass over all channels; dropping en aborts it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        svc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && en) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    svc = 1'b1;
                    if (idx_q == LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == SCAN);

    // Operands for the channel currently under service.
    always_comb begin
        cnt_cur = cnt[idx_q];
        sw_cur  = sw_s[idx_q];
        db_cur  = db[idx_q];
        cnt_inc = {1'b0, cnt_cur} + 1'b1;
    end

    // Per-channel confirm counter and debounced level; an agreeing sample clears progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db   <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            if (svc) begin
                if (sw_cur == db_cur) begin
                    cnt[idx_q] <= '0;
                end else if (cnt_inc < CONF_V) begin
                    cnt[idx_q] <= cnt_inc[CW-1:0];
                end else begin
                    cnt[idx_q]  <= '0;
                    db[idx_q]   <= sw_cur;
                    rise[idx_q] <= sw_cur;
                    fall[idx_q] <= ~sw_cur;
                end
            end
        end
    end

endmodule
